// File: rtl/debug_monitor_pkg.sv
// Shared constants for the debug monitor: bus command/response codes,
// register address map, ID string and the hex-to-7-segment decoder.
package debug_monitor_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;

  localparam logic [6:0] ADDR_NREGS  = 7'h08;
  localparam logic [6:0] ADDR_NDIG   = 7'h09;
  localparam logic [6:0] ADDR_REG    = 7'h10;
  localparam logic [6:0] ADDR_SEL    = 7'h20;
  localparam logic [6:0] ADDR_CTRL   = 7'h30;
  localparam logic [6:0] ADDR_CURSOR = 7'h31;
  localparam logic [6:0] ADDR_DISP   = 7'h40;

  // "DEBUGMX2", byte 0 in the top byte
  localparam logic [63:0] ID_STR = 64'h4445_4255_474D_5832;

  // Active-low segments {G,F,E,D,C,B,A}
  function automatic logic [6:0] hex_to_seg(input nibble_t nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

endpackage

// File: rtl/debug_monitor_if.sv
// OCP-style register bus between the debug link master and the monitor.
interface debug_monitor_if;
  logic [2:0] MCmd;
  logic [7:0] MAddr;
  logic [7:0] MData;
  logic       SCmdAccept;
  logic [7:0] SData;
  logic [1:0] SResp;

  modport master (output MCmd, MAddr, MData, input SCmdAccept, SData, SResp);
  modport slave  (input MCmd, MAddr, MData, output SCmdAccept, SData, SResp);
endinterface

// File: rtl/debug_monitor_seg7_scan.sv
// Time-multiplexed 7-segment scanner: one digit per SCAN_DIV clocks,
// registered active-low segment and digit-enable outputs.
module seg7_scan
  import debug_monitor_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_DIGITS*4-1:0] i_content,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  output logic [7:0]              o_seg_n,
  output logic [NUM_DIGITS-1:0]   o_dig_n
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] DIG_ONE = 1;

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  nibble_t          w_nib;
  logic             w_dp;

  always_comb begin
    w_nib = '0;
    w_dp  = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (r_idx == IDX_W'(d)) begin
        w_nib = i_content[4*d +: 4];
        w_dp  = i_dp[d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      o_seg_n <= 8'hFF;
      o_dig_n <= '1;
    end else begin
      if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      o_seg_n <= {~w_dp, hex_to_seg(w_nib)};
      o_dig_n <= ~(DIG_ONE << r_idx);
    end
  end

endmodule

// File: rtl/debug_monitor.sv
// Debug monitor: register slave, nibble source mux with coherent freeze,
// push-switch navigation, driving a multiplexed 7-segment display.
module debug_monitor
  import debug_monitor_pkg::*;
#(
  parameter int NUM_REGS   = 4,
  parameter int NUM_DIGITS = 4,
  parameter int PROBE_W    = 16,
  parameter int SEL_W      = 5,
  parameter int SCAN_DIV   = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  debug_monitor_if.slave        bus,
  input  logic [PROBE_W-1:0]    probe,
  input  logic [3:0]            sw_edge,
  input  logic                  sw_pushing,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam int PROBE_NIB = PROBE_W / 4;
  localparam int NUM_SRC   = PROBE_NIB + 2 * NUM_REGS;
  localparam int CUR_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SRC_TAB   = 1 << SEL_W;

  logic [7:0]       r_regs   [NUM_REGS];
  logic [SEL_W-1:0] r_sel    [NUM_DIGITS];
  nibble_t          r_disp   [NUM_DIGITS];
  logic [CUR_W-1:0] r_cursor;
  logic             r_freeze;
  logic [7:0]       r_sdata;
  logic [1:0]       r_sresp;

  nibble_t                 w_src [SRC_TAB];
  logic                    w_wr, w_rd, w_src_ok, w_cur_ok, w_unused;
  logic [6:0]              w_addr;
  logic [7:0]              w_rdata;
  logic [NUM_DIGITS*4-1:0] w_content;
  logic [NUM_DIGITS-1:0]   w_dp;

  assign w_wr     = (bus.MCmd == CMD_WR);
  assign w_rd     = (bus.MCmd == CMD_RD);
  assign w_addr   = bus.MAddr[6:0];
  assign w_unused = bus.MAddr[7];
  assign w_src_ok = (bus.MData < 8'(NUM_SRC));
  assign w_cur_ok = (bus.MData < 8'(NUM_DIGITS));

  assign bus.SCmdAccept = 1'b1;
  assign bus.SData      = r_sdata;
  assign bus.SResp      = r_sresp;

  // Padded to 2^SEL_W entries so any select value indexes safely
  for (genvar s = 0; s < SRC_TAB; s++) begin : g_src
    if (s < PROBE_NIB) begin : g_probe
      assign w_src[s] = probe[4*s +: 4];
    end else if (s < NUM_SRC) begin : g_reg
      assign w_src[s] = r_regs[(s - PROBE_NIB) / 2][4*((s - PROBE_NIB) % 2) +: 4];
    end else begin : g_none
      assign w_src[s] = 4'h0;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (w_addr == 7'(i)) w_rdata = ID_STR[8*(7-i) +: 8];
    if (w_addr == ADDR_NREGS) w_rdata = 8'(NUM_REGS);
    if (w_addr == ADDR_NDIG)  w_rdata = 8'(NUM_DIGITS);
    for (int i = 0; i < NUM_REGS; i++)
      if (w_addr == 7'(ADDR_REG + i)) w_rdata = r_regs[i];
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_addr == 7'(ADDR_SEL + d))  w_rdata = 8'(r_sel[d]);
      if (w_addr == 7'(ADDR_DISP + d)) w_rdata = {4'h0, r_disp[d]};
    end
    if (w_addr == ADDR_CTRL)   w_rdata = {7'b0, r_freeze};
    if (w_addr == ADDR_CURSOR) w_rdata = 8'(r_cursor);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
        r_sel[d]  <= '0;
        r_disp[d] <= '0;
      end
      r_cursor <= '0;
      r_freeze <= 1'b0;
      r_sdata  <= '0;
      r_sresp  <= RESP_NULL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_wr && w_addr == 7'(ADDR_REG + i)) r_regs[i] <= bus.MData;

      // An accepted bus write beats any switch action on the same select
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (w_wr && w_addr == 7'(ADDR_SEL + d) && w_src_ok)
          r_sel[d] <= SEL_W'(bus.MData);
        else if (r_cursor == CUR_W'(d) && sw_edge[0])
          r_sel[d] <= (r_sel[d] == SEL_W'(NUM_SRC - 1)) ? '0 : r_sel[d] + 1'b1;
        else if (r_cursor == CUR_W'(d) && sw_edge[1])
          r_sel[d] <= (r_sel[d] == '0) ? SEL_W'(NUM_SRC - 1) : r_sel[d] - 1'b1;
      end

      if (w_wr && w_addr == ADDR_CURSOR && w_cur_ok)
        r_cursor <= CUR_W'(bus.MData);
      else if (sw_edge[2])
        r_cursor <= (r_cursor == CUR_W'(NUM_DIGITS - 1)) ? '0 : r_cursor + 1'b1;

      if (w_wr && w_addr == ADDR_CTRL) r_freeze <= bus.MData[0];
      else if (sw_edge[3])             r_freeze <= ~r_freeze;

      if (!r_freeze)
        for (int d = 0; d < NUM_DIGITS; d++) r_disp[d] <= w_src[r_sel[d]];

      r_sresp <= w_rd ? RESP_DVA : RESP_NULL;
      if (w_rd) r_sdata <= w_rdata;
    end
  end

  always_comb begin
    w_content = '0;
    w_dp      = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      w_content[4*d +: 4] = (sw_pushing && r_cursor == CUR_W'(d)) ? 4'(r_sel[d]) : r_disp[d];
      w_dp[d]             = r_freeze || (r_cursor == CUR_W'(d));
    end
  end

  seg7_scan #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) u_scan (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_content(w_content),
    .i_dp     (w_dp),
    .o_seg_n  (seg_n),
    .o_dig_n  (dig_n)
  );

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor with hand-computed expectations.
module tb_debug_monitor;
  import debug_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] probe = '0;
  logic [3:0]  sw_edge = '0;
  logic        sw_pushing = 1'b0;
  logic [7:0]  seg_n;
  logic [3:0]  dig_n;
  int          n_checks = 0;
  int          n_errors = 0;

  debug_monitor_if bus ();

  debug_monitor #(
    .NUM_REGS(4), .NUM_DIGITS(4), .PROBE_W(16), .SEL_W(5), .SCAN_DIV(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .probe     (probe),
    .sw_edge   (sw_edge),
    .sw_pushing(sw_pushing),
    .seg_n     (seg_n),
    .dig_n     (dig_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.MCmd = CMD_WR; bus.MAddr = a; bus.MData = d;
    tick(1);
    bus.MCmd = CMD_IDLE;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    bus.MCmd = CMD_RD; bus.MAddr = a;
    tick(1);
    chk({tag, "_resp"}, bus.SResp, RESP_DVA);
    chk(tag, bus.SData, exp);
    bus.MCmd = CMD_IDLE;
  endtask

  task automatic pulse(input logic [3:0] e);
    sw_edge = e;
    tick(1);
    sw_edge = '0;
  endtask

  task automatic sync_e(output bit ok);
    logic [3:0] prev;
    ok = 1'b0;
    prev = dig_n;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick(1);
      if (dig_n == 4'hE && prev != 4'hE) ok = 1'b1;
      prev = dig_n;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] id_exp [10];
    logic [7:0] rdv;
    bit         ok;
    int         cnt;
    id_exp = '{8'h44, 8'h45, 8'h42, 8'h55, 8'h47, 8'h4D, 8'h58, 8'h32, 8'h04, 8'h04};
    bus.MCmd = CMD_IDLE; bus.MAddr = '0; bus.MData = '0;

    #2 reset_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_sdata", bus.SData, 8'h00);
    chk("rst_sresp", bus.SResp, 2'b00);
    chk("rst_seg", seg_n, 8'hFF);
    chk("rst_dig", dig_n, 4'hF);
    chk("accept", bus.SCmdAccept, 1'b1);
    reset_n = 1'b1;
    tick(1);

    // back-to-back ID / constant reads
    for (int i = 0; i < 10; i++) begin
      rdv = 8'(i);
      rd_chk($sformatf("id%0d", i), rdv, id_exp[i]);
    end
    tick(1);
    chk("resp_idle", bus.SResp, 2'b00);

    // registers, selects, out-of-range addresses
    wr(8'h11, 8'hA5);
    wr(8'h21, 8'h07);
    tick(2);
    rd_chk("disp1", 8'h41, 8'h0A);
    rd_chk("reg1", 8'h11, 8'hA5);
    rd_chk("reg1_b7", 8'h91, 8'hA5);
    rd_chk("sel1", 8'h21, 8'h07);
    wr(8'h14, 8'h77);
    rd_chk("reg_oor", 8'h14, 8'h00);
    wr(8'h22, 8'h0C);
    rd_chk("sel_oor", 8'h22, 8'h00);
    rd_chk("unmapped", 8'h3F, 8'h00);

    // switch navigation
    wr(8'h20, 8'h00);
    pulse(4'b0010);
    rd_chk("sw_dec_wrap", 8'h20, 8'h0B);
    pulse(4'b0001);
    pulse(4'b0001);
    rd_chk("sw_inc_wrap", 8'h20, 8'h01);
    pulse(4'b0011);
    rd_chk("sw_both", 8'h20, 8'h02);
    bus.MCmd = CMD_WR; bus.MAddr = 8'h20; bus.MData = 8'h05; sw_edge = 4'b0001;
    tick(1);
    bus.MCmd = CMD_IDLE; sw_edge = '0;
    rd_chk("bus_wins", 8'h20, 8'h05);
    pulse(4'b0100);
    rd_chk("cur_next", 8'h31, 8'h01);
    wr(8'h31, 8'h04);
    rd_chk("cur_oor", 8'h31, 8'h01);
    pulse(4'b0100); pulse(4'b0100); pulse(4'b0100);
    rd_chk("cur_wrap", 8'h31, 8'h00);
    pulse(4'b1000);
    rd_chk("frz_tog1", 8'h30, 8'h01);
    pulse(4'b1000);
    rd_chk("frz_tog0", 8'h30, 8'h00);

    // freeze snapshot
    probe = 16'h1234;
    wr(8'h20, 8'h00); wr(8'h21, 8'h01); wr(8'h22, 8'h02); wr(8'h23, 8'h03);
    wr(8'h30, 8'h01);
    probe = 16'hFFFF;
    tick(2);
    for (int d = 0; d < 4; d++) begin
      rdv = 8'h40 + 8'(d);
      rd_chk($sformatf("frz%0d", d), rdv, 8'(4 - d));
    end
    rd_chk("ctrl", 8'h30, 8'h01);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (seg_n[7] !== 1'b0) cnt++;
    end
    chk("frz_dp_off", cnt, 0);
    wr(8'h30, 8'h00);
    tick(1);
    for (int d = 0; d < 4; d++) begin
      rdv = 8'h40 + 8'(d);
      rd_chk($sformatf("unfrz%0d", d), rdv, 8'h0F);
    end

    // scan sequence, all digits showing 3, cursor on digit 0
    probe = 16'h3333;
    tick(2);
    sync_e(ok);
    chk("scan_sync", ok, 1);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick(1);
      chk($sformatf("scan_dig%0d", j), dig_n, 4'hF & ~(4'b0001 << (j / 4)));
      chk($sformatf("scan_seg%0d", j), seg_n, (j / 4 == 0) ? 8'h30 : 8'hB0);
    end

    // pushing: cursor digit shows its select (0) with DP lit
    sw_pushing = 1'b1;
    tick(2);
    sync_e(ok);
    chk("push_sync", ok, 1);
    chk("push_seg0", seg_n, 8'h40);
    tick(4);
    chk("push_dig1", dig_n, 4'hD);
    chk("push_seg1", seg_n, 8'hB0);
    sw_pushing = 1'b0;

    // reset mid-read and mid-scan
    bus.MCmd = CMD_RD; bus.MAddr = 8'h11;
    #3 reset_n = 1'b0;
    #1;
    chk("mr_sresp", bus.SResp, 2'b00);
    chk("mr_sdata", bus.SData, 8'h00);
    chk("mr_seg", seg_n, 8'hFF);
    chk("mr_dig", dig_n, 4'hF);
    @(posedge clk); #1;
    chk("mr_sresp_hold", bus.SResp, 2'b00);
    bus.MCmd = CMD_IDLE;
    reset_n = 1'b1;
    tick(1);
    chk("mr_sresp_after", bus.SResp, 2'b00);
    rd_chk("mr_reg1", 8'h11, 8'h00);
    rd_chk("mr_sel0", 8'h20, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
